// File: rtl/kbd_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : kbd_scan_sequencer
//  Purpose  : Sequences PS/2 Set-2 prefix bytes (E0 extended, F0 break) and
//             keeps a held-key table for W/S/A/D/Left/Right. Horizontal
//             movement uses last-pressed-wins priority. Each accepted
//             make/break emits a one-cycle key event.
//  Options  : KBD_TYPEMATIC_FILTER_EN - when defined, a make for a key that
//             is already held (auto-repeat) emits no event and leaves the
//             last-direction flag unchanged.
//  Revision : 1.0  initial release
// ============================================================================
module kbd_scan_sequencer #(
    parameter int TIMEOUT_CYCLES = 200000,
    parameter int CNT_W          = 18
) (
    input  logic       CLK100MHZ,
    input  logic       RESET,
    input  logic       code_valid,
    input  logic [7:0] code_byte,
    input  logic       code_err,
    output logic [5:0] key_state,
    output logic [1:0] move,
    output logic       evt_valid,
    output logic [2:0] evt_key,
    output logic       evt_make
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0]       c_CODE_EXT   = 8'hE0;
    localparam logic [7:0]       c_CODE_BRK   = 8'hF0;
    localparam logic [CNT_W-1:0] c_CNT_LAST   = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] c_CNT_ONE    = CNT_W'(1);

    // Key indices into key_state
    localparam logic [2:0] c_KEY_W     = 3'd0;
    localparam logic [2:0] c_KEY_S     = 3'd1;
    localparam logic [2:0] c_KEY_A     = 3'd2;
    localparam logic [2:0] c_KEY_D     = 3'd3;
    localparam logic [2:0] c_KEY_LEFT  = 3'd4;
    localparam logic [2:0] c_KEY_RIGHT = 3'd5;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [5:0]       r_key_state;
    logic [5:0]       w_key_nxt;
    logic             r_last_dir;
    logic             w_last_dir_nxt;
    logic             r_evt_valid;
    logic             w_evt_valid_nxt;
    logic [2:0]       r_evt_key;
    logic [2:0]       w_evt_key_nxt;
    logic             r_evt_make;
    logic             w_evt_make_nxt;
    logic [1:0]       r_move;
    logic [1:0]       w_move_nxt;

    logic             w_nonext_hit;
    logic [2:0]       w_nonext_idx;
    logic             w_ext_hit;
    logic [2:0]       w_ext_idx;
    logic             w_hit;
    logic             w_make;
    logic [2:0]       w_idx;
    logic             w_left_grp;
    logic             w_right_grp;

    assign key_state = r_key_state;
    assign move      = r_move;
    assign evt_valid = r_evt_valid;
    assign evt_key   = r_evt_key;
    assign evt_make  = r_evt_make;

    // Decode the incoming byte into a key index for plain and E0-prefixed codes
    always_comb begin
        w_nonext_hit = 1'b0;
        w_nonext_idx = 3'd0;
        w_ext_hit    = 1'b0;
        w_ext_idx    = 3'd0;
        case (code_byte)
            8'h1D:   begin w_nonext_hit = 1'b1; w_nonext_idx = c_KEY_W; end
            8'h1B:   begin w_nonext_hit = 1'b1; w_nonext_idx = c_KEY_S; end
            8'h1C:   begin w_nonext_hit = 1'b1; w_nonext_idx = c_KEY_A; end
            8'h23:   begin w_nonext_hit = 1'b1; w_nonext_idx = c_KEY_D; end
            8'h6B:   begin w_ext_hit    = 1'b1; w_ext_idx    = c_KEY_LEFT;  end
            8'h74:   begin w_ext_hit    = 1'b1; w_ext_idx    = c_KEY_RIGHT; end
            default: begin end
        endcase
    end

    // Next-state, timeout and key-table update; a byte always beats the timeout
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_key_nxt       = r_key_state;
        w_last_dir_nxt  = r_last_dir;
        w_evt_valid_nxt = 1'b0;
        w_evt_key_nxt   = r_evt_key;
        w_evt_make_nxt  = r_evt_make;
        w_hit           = 1'b0;
        w_make          = 1'b0;
        w_idx           = 3'd0;

        if (code_valid) begin
            w_cnt_nxt = '0;
            if (code_err) begin
                w_state_nxt = ST_IDLE;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (code_byte == c_CODE_BRK) begin
                            w_state_nxt = ST_BRK;
                        end else if (code_byte == c_CODE_EXT) begin
                            w_state_nxt = ST_EXT;
                        end else if (w_nonext_hit) begin
                            w_hit  = 1'b1;
                            w_make = 1'b1;
                            w_idx  = w_nonext_idx;
                        end
                    end
                    ST_EXT: begin
                        if (code_byte == c_CODE_BRK) begin
                            w_state_nxt = ST_EXT_BRK;
                        end else begin
                            w_state_nxt = ST_IDLE;
                            if (w_ext_hit) begin
                                w_hit  = 1'b1;
                                w_make = 1'b1;
                                w_idx  = w_ext_idx;
                            end
                        end
                    end
                    ST_BRK: begin
                        w_state_nxt = ST_IDLE;
                        if (w_nonext_hit) begin
                            w_hit = 1'b1;
                            w_idx = w_nonext_idx;
                        end
                    end
                    ST_EXT_BRK: begin
                        w_state_nxt = ST_IDLE;
                        if (w_ext_hit) begin
                            w_hit = 1'b1;
                            w_idx = w_ext_idx;
                        end
                    end
                    default: w_state_nxt = ST_IDLE;
                endcase
            end
        end else if (r_state != ST_IDLE) begin
            if (r_cnt == c_CNT_LAST) begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
            end else begin
                w_cnt_nxt = r_cnt + c_CNT_ONE;
            end
        end else begin
            w_cnt_nxt = '0;
        end

        if (w_hit) begin
            if (w_make) begin
                w_key_nxt[w_idx] = 1'b1;
`ifdef KBD_TYPEMATIC_FILTER_EN
                if (!r_key_state[w_idx]) begin
`else
                begin
`endif
                    w_evt_valid_nxt = 1'b1;
                    w_evt_key_nxt   = w_idx;
                    w_evt_make_nxt  = 1'b1;
                    // W/S are vertical and do not take part in the tie-break
                    if (w_idx == c_KEY_A || w_idx == c_KEY_LEFT) begin
                        w_last_dir_nxt = 1'b0;
                    end else if (w_idx == c_KEY_D || w_idx == c_KEY_RIGHT) begin
                        w_last_dir_nxt = 1'b1;
                    end
                end
            end else begin
                // Breaks report even when the key was not held
                w_key_nxt[w_idx] = 1'b0;
                w_evt_valid_nxt  = 1'b1;
                w_evt_key_nxt    = w_idx;
                w_evt_make_nxt   = 1'b0;
            end
        end
    end

    // Resolve horizontal movement from the registered key table
    always_comb begin
        w_left_grp  = r_key_state[c_KEY_A] | r_key_state[c_KEY_LEFT];
        w_right_grp = r_key_state[c_KEY_D] | r_key_state[c_KEY_RIGHT];
        w_move_nxt  = 2'b00;
        if (w_left_grp && w_right_grp) begin
            w_move_nxt = r_last_dir ? 2'b01 : 2'b10;
        end else if (w_left_grp) begin
            w_move_nxt = 2'b10;
        end else if (w_right_grp) begin
            w_move_nxt = 2'b01;
        end
    end

    // Prefix FSM state and inter-byte timeout counter
    always_ff @(posedge CLK100MHZ or posedge RESET) begin
        if (RESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Key table, direction memory and event outputs
    always_ff @(posedge CLK100MHZ or posedge RESET) begin
        if (RESET) begin
            r_key_state <= 6'd0;
            r_last_dir  <= 1'b0;
            r_evt_valid <= 1'b0;
            r_evt_key   <= 3'd0;
            r_evt_make  <= 1'b0;
        end else begin
            r_key_state <= w_key_nxt;
            r_last_dir  <= w_last_dir_nxt;
            r_evt_valid <= w_evt_valid_nxt;
            r_evt_key   <= w_evt_key_nxt;
            r_evt_make  <= w_evt_make_nxt;
        end
    end

    // Movement register, one cycle behind the key table
    always_ff @(posedge CLK100MHZ or posedge RESET) begin
        if (RESET) begin
            r_move <= 2'b00;
        end else begin
            r_move <= w_move_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_kbd_scan_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_kbd_scan_sequencer
//  Purpose  : Self-checking bench for kbd_scan_sequencer: directed scenarios
//             followed by random byte streams compared with a behavioural
//             model of held keys, pending prefixes and last-pressed priority.
//  Revision : 1.0  initial release
// ============================================================================
module tb_kbd_scan_sequencer;

    localparam int TMO   = 20;
    localparam int CNT_W = 5;

    logic       CLK100MHZ = 1'b0;
    logic       RESET     = 1'b1;
    logic       code_valid = 1'b0;
    logic [7:0] code_byte  = 8'h00;
    logic       code_err   = 1'b0;
    logic [5:0] key_state;
    logic [1:0] move;
    logic       evt_valid;
    logic [2:0] evt_key;
    logic       evt_make;

    int n_checks = 0;
    int n_errors = 0;
    int cyc      = 0;

    // Behavioural model: held keys, last direction, pending prefix
    bit m_keys [6];
    bit m_last_dir;
    bit m_pending;
    bit m_pend_brk;
    bit m_pend_ext;
    int m_pend_cyc;

    kbd_scan_sequencer #(
        .TIMEOUT_CYCLES(TMO),
        .CNT_W         (CNT_W)
    ) dut (
        .CLK100MHZ (CLK100MHZ),
        .RESET     (RESET),
        .code_valid(code_valid),
        .code_byte (code_byte),
        .code_err  (code_err),
        .key_state (key_state),
        .move      (move),
        .evt_valid (evt_valid),
        .evt_key   (evt_key),
        .evt_make  (evt_make)
    );

    always #5 CLK100MHZ = ~CLK100MHZ;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK100MHZ);
        cyc++;
        #1;
    endtask

    // Key lookup: returns -1 for bytes that do not map to a tracked key
    function automatic int map_key(input bit ext, input logic [7:0] b);
        if (!ext) begin
            case (b)
                8'h1D: return 0;
                8'h1B: return 1;
                8'h1C: return 2;
                8'h23: return 3;
                default: return -1;
            endcase
        end else begin
            case (b)
                8'h6B: return 4;
                8'h74: return 5;
                default: return -1;
            endcase
        end
    endfunction

    function automatic logic [5:0] model_keys();
        logic [5:0] v;
        for (int i = 0; i < 6; i++) v[i] = m_keys[i];
        return v;
    endfunction

    function automatic logic [1:0] model_move();
        bit l;
        bit r;
        l = m_keys[2] || m_keys[4];
        r = m_keys[3] || m_keys[5];
        if (l && r) return m_last_dir ? 2'b01 : 2'b10;
        if (l)      return 2'b10;
        if (r)      return 2'b01;
        return 2'b00;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 6; i++) m_keys[i] = 1'b0;
        m_last_dir = 1'b0;
        m_pending  = 1'b0;
        m_pend_brk = 1'b0;
        m_pend_ext = 1'b0;
        m_pend_cyc = 0;
    endtask

    // Send one byte, then compare events/keys after the sampling edge and
    // movement one edge later
    task automatic send(input logic [7:0] b, input bit err);
        bit exp_ev;
        bit exp_mk;
        int k;
        int idx;
        exp_ev = 1'b0;
        exp_mk = 1'b0;
        k      = 0;
        code_valid = 1'b1;
        code_byte  = b;
        code_err   = err;
        step();
        if (err) begin
            m_pending = 1'b0;
        end else begin
            if (m_pending && (cyc - m_pend_cyc) > TMO) m_pending = 1'b0;
            if (!m_pending) begin
                if (b == 8'hF0) begin
                    m_pending = 1'b1; m_pend_ext = 1'b0; m_pend_brk = 1'b1; m_pend_cyc = cyc;
                end else if (b == 8'hE0) begin
                    m_pending = 1'b1; m_pend_ext = 1'b1; m_pend_brk = 1'b0; m_pend_cyc = cyc;
                end else begin
                    idx = map_key(1'b0, b);
                    if (idx >= 0) begin exp_mk = 1'b1; k = idx; exp_ev = 1'b1; end
                end
            end else if (m_pend_ext && !m_pend_brk && b == 8'hF0) begin
                m_pend_brk = 1'b1;
                m_pend_cyc = cyc;
            end else begin
                m_pending = 1'b0;
                idx = map_key(m_pend_ext, b);
                if (idx >= 0) begin exp_mk = !m_pend_brk; k = idx; exp_ev = 1'b1; end
            end
        end
        if (exp_ev) begin
            if (exp_mk) begin
`ifdef KBD_TYPEMATIC_FILTER_EN
                if (m_keys[k]) exp_ev = 1'b0;
`endif
                m_keys[k] = 1'b1;
                if (exp_ev && (k == 2 || k == 4)) m_last_dir = 1'b0;
                if (exp_ev && (k == 3 || k == 5)) m_last_dir = 1'b1;
            end else begin
                m_keys[k] = 1'b0;
            end
        end
        check_eq("evt_valid", 32'(evt_valid), 32'(exp_ev));
        if (exp_ev) begin
            check_eq("evt_key",  32'(evt_key),  32'(k));
            check_eq("evt_make", 32'(evt_make), 32'(exp_mk));
        end
        check_eq("key_state", 32'(key_state), 32'(model_keys()));
        code_valid = 1'b0;
        code_err   = 1'b0;
        step();
        check_eq("move", 32'(move), 32'(model_move()));
        check_eq("evt_pulse_end", 32'(evt_valid), 32'd0);
    endtask

    task automatic gap(input int n);
        repeat (n) step();
    endtask

    task automatic pulse_reset();
        RESET = 1'b1;
        #2;
        check_eq("rst_key_state", 32'(key_state), 32'd0);
        check_eq("rst_move",      32'(move),      32'd0);
        check_eq("rst_evt_valid", 32'(evt_valid), 32'd0);
        step();
        RESET = 1'b0;
        model_reset();
        step();
    endtask

    logic [7:0] pool [10] = '{8'h1D, 8'h1B, 8'h1C, 8'h23, 8'h6B,
                              8'h74, 8'hE0, 8'hF0, 8'h12, 8'h00};

    initial begin
        model_reset();
        #1;
        check_eq("init_key_state", 32'(key_state), 32'd0);
        check_eq("init_move",      32'(move),      32'd0);
        check_eq("init_evt_valid", 32'(evt_valid), 32'd0);
        check_eq("init_evt_key",   32'(evt_key),   32'd0);
        check_eq("init_evt_make",  32'(evt_make),  32'd0);
        step();
        RESET = 1'b0;
        step();

        // A make and break
        send(8'h1C, 1'b0);
        send(8'hF0, 1'b0); send(8'h1C, 1'b0);
        // Right held, then A overrides, then A released
        send(8'hE0, 1'b0); send(8'h74, 1'b0);
        send(8'h1C, 1'b0);
        send(8'hF0, 1'b0); send(8'h1C, 1'b0);
        send(8'hE0, 1'b0); send(8'hF0, 1'b0); send(8'h74, 1'b0);
        // Prefix timeout: long silence drops the prefix
        send(8'hE0, 1'b0); gap(TMO); send(8'h74, 1'b0);
        // Timeout boundary: last cycle where the follow-up still counts
        send(8'hE0, 1'b0); gap(TMO - 2); send(8'h74, 1'b0);
        send(8'hE0, 1'b0); gap(TMO - 1); send(8'hF0, 1'b0); send(8'h74, 1'b0);
        // Errored break prefix, then a clean A is a make
        send(8'hF0, 1'b1); send(8'h1C, 1'b0);
        // Auto-repeat of W
        send(8'h1D, 1'b0); send(8'h1D, 1'b0); send(8'h1D, 1'b0);
        // Unmapped plain keypad codes
        send(8'h6B, 1'b0); send(8'h74, 1'b0);
        // Reset with an extended break pending
        send(8'h1C, 1'b0); send(8'h23, 1'b0);
        send(8'hE0, 1'b0); send(8'hF0, 1'b0);
        pulse_reset();
        send(8'h6B, 1'b0);

        // Random byte streams with gaps clustered around the timeout boundary
        for (int i = 0; i < 400; i++) begin
            int r;
            logic [7:0] b;
            r = $urandom_range(0, 9);
            if (r < 6)      gap($urandom_range(0, 3));
            else if (r < 9) gap(TMO - 4 + $urandom_range(0, 6));
            else            gap($urandom_range(0, 2 * TMO));
            if ($urandom_range(0, 19) == 0) b = 8'($urandom);
            else                            b = pool[$urandom_range(0, 9)];
            send(b, $urandom_range(0, 15) == 0);
            if (i == 200) pulse_reset();
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
